// File: rtl/rx_ctrl_pkg.sv
// Shared definitions for the RX buffer controller: FSM state codes,
// the RX status alert bit position and the default buffer depth.
package rx_ctrl_pkg;

  localparam int DEFAULT_BUF_DEPTH   = 32;
  localparam int RX_STATUS_ALERT_BIT = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_DISABLED  = 2'd0;
  localparam state_t ST_ARMED     = 2'd1;
  localparam state_t ST_RECEIVING = 2'd2;
  localparam state_t ST_MSG_AVAIL = 2'd3;

endpackage

// File: rtl/rx_buffer_controller_if.sv
// Bundle of the Rx write strobe, host read handshake and RX buffer RAM port.
// The slave side is the controller; the master side is its environment.
interface rx_buffer_controller_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();

  logic              Rx_WR_VALID;
  logic [ADDR_W-1:0] Rx_DIR_WRITE;
  logic [DATA_W-1:0] Rx_DATA;
  logic              Host_RD_REQ;
  logic [ADDR_W-1:0] Host_RD_ADDR;
  logic [DATA_W-1:0] oHost_RD_DATA;
  logic              oHost_RD_ACK;
  logic [ADDR_W-1:0] oBUF_ADDR;
  logic [DATA_W-1:0] oBUF_WDATA;
  logic              oBUF_WE;
  logic [DATA_W-1:0] BUF_RDATA;

  modport slave (
    input  Rx_WR_VALID, Rx_DIR_WRITE, Rx_DATA, Host_RD_REQ, Host_RD_ADDR, BUF_RDATA,
    output oHost_RD_DATA, oHost_RD_ACK, oBUF_ADDR, oBUF_WDATA, oBUF_WE
  );

  modport master (
    output Rx_WR_VALID, Rx_DIR_WRITE, Rx_DATA, Host_RD_REQ, Host_RD_ADDR, BUF_RDATA,
    input  oHost_RD_DATA, oHost_RD_ACK, oBUF_ADDR, oBUF_WDATA, oBUF_WE
  );

endinterface

// File: rtl/rx_buf_port_arb.sv
// Single RAM port mux: Rx writes take the port, otherwise a host read is
// issued and acknowledged one cycle later with the RAM's registered data.
module rx_buf_port_arb #(
  parameter int BUF_DEPTH = 32,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] buf_rdata,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_wdata,
  output logic              buf_we,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_ack
);

  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(BUF_DEPTH);

  logic ack_q, ack_d;
  logic oor_q, oor_d;
  logic rd_in_range;
  logic issue;

  assign rd_in_range = {1'b0, rd_addr} < DEPTH_A;
  // The ack cycle counts as in flight, so a held request re-issues one cycle later.
  assign issue       = rd_req && !ack_q && !wr_en && !reset;

  always_comb begin
    buf_addr  = '0;
    buf_wdata = '0;
    buf_we    = 1'b0;
    if (wr_en) begin
      buf_we    = 1'b1;
      buf_addr  = wr_addr;
      buf_wdata = wr_data;
    end else if (issue && rd_in_range) begin
      buf_addr = rd_addr;
    end
  end

  always_comb begin
    ack_d = issue;
    oor_d = issue && !rd_in_range;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q <= 1'b0;
      oor_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
      oor_q <= oor_d;
    end
  end

  assign rd_ack  = ack_q;
  assign rd_data = (ack_q && !oor_q) ? buf_rdata : '0;

endmodule

// File: rtl/rx_buffer_controller.sv
// Rx engine sequencer: arms reception, issues the start pulse, latches the
// message byte count and sticky alert/overflow flags, and owns the RX buffer.
module rx_buffer_controller
  import rx_ctrl_pkg::*;
#(
  parameter int BUF_DEPTH = DEFAULT_BUF_DEPTH,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] iRECEIVE_DETECT,
  input  logic       CC_IDLE,
  input  logic       Tx_State_Machine_ACTIVE,
  output logic       oStart,
  input  logic       Rx_MSG_DONE,
  input  logic       Rx_MSG_ABORT,
  input  logic [7:0] Rx_BYTE_COUNT,
  input  logic       Host_ALERT_CLR,
  output logic [7:0] oRECEIVE_BYTE_COUNT,
  output logic       oALERT_RX_STATUS,
  output logic       oRX_OVERFLOW,
  rx_buffer_controller_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(BUF_DEPTH);
  localparam logic [8:0]      DEPTH_C = 9'(BUF_DEPTH);

  state_t     state_q, state_d;
  logic       start_q, start_d;
  logic [7:0] count_q, count_d;
  logic       alert_q, alert_d;
  logic       ovf_q, ovf_d;
  logic       wr_in_range;
  logic       rx_wr_en;
  logic       enabled;

  assign enabled     = iRECEIVE_DETECT != 8'd0;
  assign wr_in_range = {1'b0, bus.Rx_DIR_WRITE} < DEPTH_A;
  assign rx_wr_en    = bus.Rx_WR_VALID && wr_in_range && (state_q == ST_RECEIVING) && !reset;

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    count_d = count_q;
    alert_d = alert_q;
    ovf_d   = ovf_q;
    if (Host_ALERT_CLR) ovf_d = 1'b0;
    case (state_q)
      ST_DISABLED: begin
        if (enabled) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!enabled) begin
          state_d = ST_DISABLED;
        end else if (CC_IDLE && !Tx_State_Machine_ACTIVE) begin
          start_d = 1'b1;
          state_d = ST_RECEIVING;
        end
      end
      ST_RECEIVING: begin
        if (bus.Rx_WR_VALID && !wr_in_range) ovf_d = 1'b1;
        if (!enabled) begin
          state_d = ST_DISABLED;
        end else if (Rx_MSG_ABORT) begin
          state_d = ST_ARMED;
        end else if (Rx_MSG_DONE) begin
          count_d = ({1'b0, Rx_BYTE_COUNT} > DEPTH_C) ? DEPTH_C[7:0] : Rx_BYTE_COUNT;
          alert_d = 1'b1;
          state_d = ST_MSG_AVAIL;
        end
      end
      ST_MSG_AVAIL: begin
        if (bus.Rx_WR_VALID) ovf_d = 1'b1;
        // Clearing the alert releases the buffer back to the Rx engine.
        if (Host_ALERT_CLR) begin
          alert_d = 1'b0;
          count_d = 8'd0;
          ovf_d   = 1'b0;
          state_d = enabled ? ST_ARMED : ST_DISABLED;
        end
      end
      default: state_d = ST_DISABLED;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= ST_DISABLED;
      start_q <= 1'b0;
      count_q <= 8'd0;
      alert_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      count_q <= count_d;
      alert_q <= alert_d;
      ovf_q   <= ovf_d;
    end
  end

  assign oStart              = start_q;
  assign oRECEIVE_BYTE_COUNT = count_q;
  assign oALERT_RX_STATUS    = alert_q;
  assign oRX_OVERFLOW        = ovf_q;

  rx_buf_port_arb #(
    .BUF_DEPTH (BUF_DEPTH),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W)
  ) u_port_arb (
    .clk       (CLK),
    .reset     (reset),
    .wr_en     (rx_wr_en),
    .wr_addr   (bus.Rx_DIR_WRITE),
    .wr_data   (bus.Rx_DATA),
    .rd_req    (bus.Host_RD_REQ),
    .rd_addr   (bus.Host_RD_ADDR),
    .buf_rdata (bus.BUF_RDATA),
    .buf_addr  (bus.oBUF_ADDR),
    .buf_wdata (bus.oBUF_WDATA),
    .buf_we    (bus.oBUF_WE),
    .rd_data   (bus.oHost_RD_DATA),
    .rd_ack    (bus.oHost_RD_ACK)
  );

endmodule
